// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with fixed wait states.
// Optional macro BE_MASK_EN: byte-enable masked writes (default: full-word writes, req_be ignored).
module mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h00400000,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] ERR_WORD  = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    logic [31:0] mem [DEPTH];

    logic             accept;
    logic             enter_resp;
    logic             commit;
    logic             op_we;
    logic [31:0]      op_addr;
    logic [31:0]      op_wdata;
    logic [3:0]       op_be;
    logic [32:0]      offset;
    logic             op_ok;
    logic [IDX_W-1:0] op_idx;
    logic [31:0]      wr_word;
    logic [31:0]      rsp_rdata_d;
    logic             be_unused;

    // With zero wait states the access completes on the acceptance edge, so the
    // operation is taken straight from the request port instead of the capture registers.
    always_comb begin
        accept     = (state == IDLE) && req_valid;
        enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd0));

        op_we    = (state == IDLE) ? req_we    : cap_we;
        op_addr  = (state == IDLE) ? req_addr  : cap_addr;
        op_wdata = (state == IDLE) ? req_wdata : cap_wdata;
        op_be    = (state == IDLE) ? req_be    : cap_be;

        // Borrow in bit 32 flags addresses below the base.
        offset = {1'b0, op_addr} - {1'b0, BASE_ADDR};
        op_ok  = !offset[32] && (offset[31:0] < SPAN) && (op_addr[1:0] == 2'b00);
        op_idx = offset[IDX_W+1:2];

`ifdef BE_MASK_EN
        wr_word   = mem[op_idx];
        be_unused = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (op_be[i]) begin
                wr_word[8*i +: 8] = op_wdata[8*i +: 8];
            end
        end
`else
        wr_word   = op_wdata;
        be_unused = ^op_be;
`endif

        if (!op_ok) begin
            rsp_rdata_d = ERR_WORD;
        end else if (op_we) begin
            rsp_rdata_d = '0;
        end else begin
            rsp_rdata_d = mem[op_idx];
        end

        commit = enter_resp && op_ok && op_we && !rst;
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[op_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_be    <= req_be;
                        req_ready <= 1'b0;
                        cnt       <= CNT_INIT;
                        if (enter_resp) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= !op_ok;
                            rsp_rdata <= rsp_rdata_d;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (enter_resp) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !op_ok;
                        rsp_rdata <= rsp_rdata_d;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h00400000: byte address of word 0.
REQ-002 Parameter DEPTH, default 256: number of 32-bit words stored; power of two, 16..4096.
REQ-003 Parameter WAIT_CYCLES, default 2: wait states per access, 0..15.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, the rising-edge clock; rst input 1, the synchronous active-high reset.
REQ-005 req_valid input 1: the initiator presents a request.
REQ-006 req_ready output 1: the responder accepts a request this cycle.
REQ-007 req_we input 1: 1 = write, 0 = read.
REQ-008 req_addr input 32: byte address.
REQ-009 req_wdata input 32: write data.
REQ-010 req_be input 4: byte enables; bit i selects bits [8i+7:8i].
REQ-011 rsp_valid output 1: a response is present.
REQ-012 rsp_ready input 1: the initiator consumes the response.
REQ-013 rsp_rdata output 32: read data.
REQ-014 rsp_err output 1: the access was rejected.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP. req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1. On acceptance, the block SHALL capture req_we, req_addr, req_wdata and req_be into internal registers.
REQ-017 On acceptance, the state SHALL go IDLE->WAIT with a 4-bit counter loaded to WAIT_CYCLES-1. If WAIT_CYCLES=0, the state SHALL go IDLE->RESP directly.
REQ-018 In WAIT, the counter SHALL decrement each cycle. The state SHALL go WAIT->RESP on the edge where the counter equals 0.
REQ-019 rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-020 An address SHALL be in range when BASE_ADDR <= req_addr < BASE_ADDR+4*DEPTH. The word index SHALL be (req_addr-BASE_ADDR)>>2.
REQ-021 If the address is out of range or req_addr[1:0]!=0, the block SHALL return rsp_err=1 and rsp_rdata=32'hDEADBEEF, and SHALL NOT modify storage.
REQ-022 A valid write SHALL commit to storage on the edge entering RESP. rsp_rdata SHALL be 0 and rsp_err SHALL be 0.
REQ-023 A valid read SHALL sample storage on the edge entering RESP. rsp_rdata SHALL hold the stored word and rsp_err SHALL be 0.
REQ-024 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1. On that edge, the state SHALL go RESP->IDLE.
REQ-025 req_valid SHALL be ignored outside IDLE; no request SHALL be queued. After the response handshake, req_ready SHALL be 1 in the following cycle.
REQ-026 rsp_ready asserted while rsp_valid=0 SHALL have no effect.
REQ-027 Changes on the req_* inputs after acceptance SHALL NOT affect the outstanding access.

Reset
REQ-028 When rst=1 at an edge: state SHALL become IDLE, the counter SHALL become 0, rsp_valid SHALL become 0, rsp_err SHALL become 0, rsp_rdata SHALL become 32'h0, and req_ready SHALL be 1 in the cycle after reset.
REQ-029 Reset during WAIT or RESP SHALL abort the access. A write aborted before entering RESP SHALL NOT commit.
REQ-030 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-031 With BE_MASK_EN defined, a write SHALL update only the bytes whose req_be bit is 1. req_be=4'b0000 SHALL leave the word unchanged but still produce a response.
REQ-032 Without BE_MASK_EN, req_be SHALL be ignored and every valid write SHALL replace the full word. The port SHALL remain present.

Verification
REQ-033 With WAIT_CYCLES=2: write 32'hCAFEF00D to 32'h00400010, then read 32'h00400010. Required: each rsp_valid rises 3 cycles after acceptance; the read returns rdata=32'hCAFEF00D with err=0.
REQ-034 Read 32'h00400002 (misaligned) and 32'h00500000 (out of range). Required: err=1, rdata=32'hDEADBEEF, and storage unchanged.
REQ-035 With BE_MASK_EN defined: write 32'h11223344, then write 32'hAABBCCDD with be=4'b0101, then read. Required: 32'h11BB33DD. Without BE_MASK_EN, the same sequence SHALL read 32'hAABBCCDD.
REQ-036 Hold rsp_ready=0 for 5 cycles while in RESP. Required: outputs stable, req_ready=0 throughout. After rsp_ready=1, req_ready=1 next cycle.
REQ-037 Assert rst in WAIT of a write of 32'h12345678 to a word holding 32'h0. Required: rsp_valid=0 and req_ready=1 after reset, and a subsequent read returns 32'h0.
REQ-038 With WAIT_CYCLES=0: issue back-to-back reads with rsp_ready tied to 1. Required: a response every 2 cycles, with rsp_valid asserted 1 cycle after each acceptance.
